sram_ctrl: RTL
==============

# sram_ctrl

Synchronous controller that services processor memory requests and drives the board-level asynchronous SRAM pins. It handles chip enable, output enable, write enable, address and the split data bus. It sits between the processor's memory port (MemWrite / Adr / MemData) and the SRAM. It sequences each access through setup, strobe and hold phases so the SRAM sees glitch-free, correctly ordered control signals with guaranteed bus turnaround. Request-side handshake is req/ready. Read data returns with a one-cycle rvalid pulse.

## Interface
- ADDR_W, 8, address width
- DATA_W, 16, data width
- SETUP_CYC, 1, cycles address/ce_n valid before strobe (≥1)
- STROBE_CYC, 2, cycles oe_n/we_n asserted (≥1)
- HOLD_CYC, 1, cycles after strobe deassert before release (≥1)

Ports:
- clk1  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- req  in  1  access request
- wr  in  1  1 = write, 0 = read; sampled with req
- adr  in  ADDR_W  request address
- wdata  in  DATA_W  write data
- ready  out  1  controller idle, request accepted this cycle if req=1
- rdata  out  DATA_W  read data, valid while rvalid=1, held until next read capture
- rvalid  out  1  one-cycle read-completion pulse
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_adr  out  ADDR_W  SRAM address
- sram_dout  out  DATA_W  data toward SRAM
- sram_dout_oe  out  1  tristate enable for sram_dout (board/top does the tristate)
- sram_din  in  DATA_W  data from SRAM

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. One down-counter, width sized for max(SETUP_CYC, STROBE_CYC, HOLD_CYC).
- IDLE:
  - ready=1, ce_n=oe_n=we_n=1, dout_oe=0.
  - On req=1, latch adr, wdata and wr into registers, load counter, and go to SETUP.
- SETUP (SETUP_CYC cycles):
  - ce_n=0 and sram_adr = latched address.
  - On writes, dout_oe=1 and sram_dout = latched data.
  - oe_n and we_n stay 1.
- STROBE (STROBE_CYC cycles): the SETUP outputs hold, plus oe_n=0 on a read or we_n=0 on a write.
  - On a read, the rising edge ending the last STROBE cycle captures sram_din into rdata.
- HOLD (HOLD_CYC cycles):
  - oe_n=we_n=1 and ce_n=0.
  - Address stays stable.
  - On writes, dout_oe=1 and data stays stable.
  - rvalid=1 in the first HOLD cycle of a read only.
  - After the last HOLD cycle, go to IDLE.
- ready=0 in every state except IDLE. req outside IDLE is ignored and never queued.
- sram_adr and sram_dout keep their last latched values in IDLE. They change only on accept.
- All SRAM-side outputs are registered (no combinational decode to pins). oe_n and we_n are never low simultaneously.
- Reset (async, any state) forces IDLE and sets:
  - ready=1
  - ce_n=oe_n=we_n=1
  - dout_oe=0
  - sram_adr=0, sram_dout=0
  - rdata=0, rvalid=0
- An in-flight write aborted by reset is not retried.

## Timing
- Accept edge = rising edge where state=IDLE and req=1; call the following cycle 1.
- Cycles per phase:
  - ce_n low for SETUP_CYC+STROBE_CYC+HOLD_CYC cycles.
  - Strobe low for STROBE_CYC cycles, starting in cycle SETUP_CYC+1.
- Read: rvalid high in cycle SETUP_CYC+STROBE_CYC+1 (default: cycle 4).
- ready returns in cycle SETUP_CYC+STROBE_CYC+HOLD_CYC+1 (default: cycle 5).
- Back-to-back requests: at least one IDLE cycle (ce_n=1, dout_oe=0) separates consecutive accesses. This guarantees bus turnaround between write and read.
- Max throughput: one access per SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles (default 5).

## Test plan
- Write 0x1234 to 0x05 (defaults):
  - sram_we_n low exactly cycles 2–3 and sram_ce_n low cycles 1–4.
  - sram_dout_oe=1 with sram_dout=0x1234 and sram_adr=0x05 stable cycles 1–4.
  - sram_oe_n stays 1 and ready=1 in cycle 5.
- Read 0x05 against the SRAM behavioural model after the previous write:
  - sram_oe_n low cycles 2–3 and sram_dout_oe=0 throughout.
  - rvalid pulses only in cycle 4 with rdata=0x1234.
- Write then read with req held high continuously:
  - Exactly one IDLE cycle between the accesses, with ce_n=1 and dout_oe=0.
  - Read accepted on the cycle-5 edge and read returns 0x1234.
- Busy request: during the STROBE of a write to 0x05, toggle req with adr=0x77, wr=0.
  - No effect: sram_adr stays 0x05 and no second access occurs until ready=1.
- Reset asserted mid-STROBE of a write of 0xBEEF to 0x05 (previous content 0x1234):
  - we_n=1 and dout_oe=0 asynchronously before the next clock edge, with ready=1 and rvalid=0.
  - A subsequent read of 0x05 returns 0x1234 if the model write had not completed.
- SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2, read:
  - oe_n low cycles 3–5.
  - rvalid in cycle 6.
  - ready=1 in cycle 8.

Source files
------------

// File: rtl/sram_ctrl.sv
// Synchronous front end for a board-level asynchronous SRAM: each accepted request is
// sequenced through SETUP, STROBE and HOLD phases with registered, glitch-free pin drive.
module sram_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic              clk1,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] adr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic [ADDR_W-1:0] sram_adr,
   output logic [DATA_W-1:0] sram_dout,
   output logic              sram_dout_oe,
   input  logic [DATA_W-1:0] sram_din,
   output logic [1:0]        dbg_state
);

   localparam int MAX_SU  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int MAX_CYC = (MAX_SU > HOLD_CYC) ? MAX_SU : HOLD_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic                ce_n_q, ce_n_d;
   logic                oe_n_q, oe_n_d;
   logic                we_n_q, we_n_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                dout_oe_q, dout_oe_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rvalid_q, rvalid_d;

   // Handshake: a request transfers on a rising edge where req=1 and ready=1 (IDLE only);
   // req while ready=0 is dropped, never queued. Pin values are computed for the next state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      ce_n_d    = ce_n_q;
      oe_n_d    = oe_n_q;
      we_n_d    = we_n_q;
      adr_d     = adr_q;
      dout_d    = dout_q;
      dout_oe_d = dout_oe_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d   = ST_SETUP;
               cnt_d     = SETUP_LD;
               wr_d      = wr;
               adr_d     = adr;
               dout_d    = wdata;
               ce_n_d    = 1'b0;
               dout_oe_d = wr;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_STROBE;
               cnt_d   = STROBE_LD;
               oe_n_d  = wr_q;
               we_n_d  = ~wr_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
               oe_n_d  = 1'b1;
               we_n_d  = 1'b1;
               // sram_din is sampled while oe_n is still low on this edge
               if (!wr_q) begin
                  rdata_d  = sram_din;
                  rvalid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               state_d   = ST_IDLE;
               ce_n_d    = 1'b1;
               dout_oe_d = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            ce_n_d    = 1'b1;
            oe_n_d    = 1'b1;
            we_n_d    = 1'b1;
            dout_oe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         ce_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
         adr_q     <= '0;
         dout_q    <= '0;
         dout_oe_q <= 1'b0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         ce_n_q    <= ce_n_d;
         oe_n_q    <= oe_n_d;
         we_n_q    <= we_n_d;
         adr_q     <= adr_d;
         dout_q    <= dout_d;
         dout_oe_q <= dout_oe_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
      end
   end

   assign ready        = (state_q == ST_IDLE);
   assign rdata        = rdata_q;
   assign rvalid       = rvalid_q;
   assign sram_ce_n    = ce_n_q;
   assign sram_oe_n    = oe_n_q;
   assign sram_we_n    = we_n_q;
   assign sram_adr     = adr_q;
   assign sram_dout    = dout_q;
   assign sram_dout_oe = dout_oe_q;
   assign dbg_state    = state_q;

endmodule
